// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline flow controller.
package pipe_pkg;

  // Controller operating state.
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

  // Edges needed to push the last pre-halt instruction out of MEM/WB.
  localparam int unsigned DRAIN_CYCLES = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc until the counter is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Resolves hazard-unit requests into per-stage enables and valid bits for the
// 5-stage pipeline, drains on halt and keeps saturating event counters.
module pipe_flow_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dmem_busy,
  input  logic             ld_use_stall,
  input  logic             flush,
  input  logic             imem_busy,
  input  logic             halt_dec,
  output logic             pc_we,
  output logic             fd_we,
  output logic             pipe_we,
  output logic             fd_valid,
  output logic             de_valid,
  output logic             em_valid,
  output logic             mw_valid,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e     state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       fd_q, de_q, em_q, mw_q;
  logic       fd_d, de_d, em_d, mw_d;
  logic       pc_we_c, fd_we_c;
  logic       freeze;
  logic       stall_inc, flush_inc;

  // Priority resolution of competing requests and next-state of the valid shift.
  always_comb begin
    freeze    = dmem_busy & (state_q != HALTED);
    pc_we_c   = 1'b0;
    fd_we_c   = 1'b0;
    fd_d      = fd_q;
    de_d      = de_q;
    em_d      = em_q;
    mw_d      = mw_q;
    state_d   = state_q;
    drain_d   = drain_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state_q)
      RUN: begin
        if (dmem_busy) begin
          stall_inc = 1'b1;
        end else if (ld_use_stall) begin
          // IF/ID holds its instruction, a bubble enters ID/EX.
          de_d      = 1'b0;
          em_d      = de_q;
          mw_d      = em_q;
          stall_inc = 1'b1;
        end else begin
          // All remaining cases load IF/ID and advance the back end.
          fd_we_c = 1'b1;
          fd_d    = 1'b0;
          de_d    = fd_q;
          em_d    = de_q;
          mw_d    = em_q;
          if (flush) begin
            pc_we_c   = 1'b1;
            flush_inc = 1'b1;
          end else if (halt_dec && fd_q) begin
            state_d = DRAIN;
            drain_d = 2'(DRAIN_CYCLES);
          end else if (imem_busy) begin
            stall_inc = 1'b1;
          end else begin
            pc_we_c = 1'b1;
            fd_d    = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Only a data-memory stall can hold the drain; other requests are moot.
        if (!dmem_busy) begin
          fd_we_c = 1'b1;
          fd_d    = 1'b0;
          de_d    = fd_q;
          em_d    = de_q;
          mw_d    = em_q;
          drain_d = drain_q - 2'd1;
          if (drain_q == 2'd1) begin
            state_d = HALTED;
            de_d    = 1'b0;
            em_d    = 1'b0;
            mw_d    = 1'b0;
          end
        end
      end
      HALTED: begin
        fd_d = 1'b0;
        de_d = 1'b0;
        em_d = 1'b0;
        mw_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  // Controller state, drain counter and stage valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= 2'd0;
      fd_q    <= 1'b0;
      de_q    <= 1'b0;
      em_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      fd_q    <= fd_d;
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
    end
  end

  // Enables are forced low while reset is held.
  always_comb begin
    pc_we    = pc_we_c & ~rst;
    fd_we    = fd_we_c & ~rst;
    pipe_we  = ~freeze & (state_q != HALTED) & ~rst;
    retire   = mw_q & ~freeze & (state_q != HALTED) & ~rst;
    halted   = (state_q == HALTED);
    fd_valid = fd_q;
    de_valid = de_q;
    em_valid = em_q;
    mw_valid = mw_q;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .inc (retire),
    .cnt (retire_cnt)
  );

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboard bench: the driver pushes hand-computed expectations per cycle,
// the monitor pops and compares mid-cycle on the falling edge.
module tb_pipe_flow_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dmem_busy = 1'b0, ld_use_stall = 1'b0, flush = 1'b0, imem_busy = 1'b0, halt_dec = 1'b0;

  logic        pc_we, fd_we, pipe_we, fd_valid, de_valid, em_valid, mw_valid, retire, halted;
  logic [15:0] stall_cnt, flush_cnt, retire_cnt;
  logic        s_pc_we, s_fd_we, s_pipe_we, s_fd_valid, s_de_valid, s_em_valid, s_mw_valid;
  logic        s_retire, s_halted;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_retire_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [4:0] ctl;   // pc_we fd_we pipe_we retire halted
    logic [3:0] vld;   // fd de em mw
    int         st;
    int         fl;
    int         rc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dmem_busy(dmem_busy), .ld_use_stall(ld_use_stall), .flush(flush),
    .imem_busy(imem_busy), .halt_dec(halt_dec), .pc_we(pc_we), .fd_we(fd_we),
    .pipe_we(pipe_we), .fd_valid(fd_valid), .de_valid(de_valid), .em_valid(em_valid),
    .mw_valid(mw_valid), .retire(retire), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
  );

  pipe_flow_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .dmem_busy(dmem_busy), .ld_use_stall(ld_use_stall), .flush(flush),
    .imem_busy(imem_busy), .halt_dec(halt_dec), .pc_we(s_pc_we), .fd_we(s_fd_we),
    .pipe_we(s_pipe_we), .fd_valid(s_fd_valid), .de_valid(s_de_valid),
    .em_valid(s_em_valid), .mw_valid(s_mw_valid), .retire(s_retire), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .retire_cnt(s_retire_cnt)
  );

  task automatic check(input string name, input int c, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, req);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Monitor: compare every output the DUTs present in this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc_we",      e.cyc, int'(pc_we),      int'(e.ctl[4]));
      check("fd_we",      e.cyc, int'(fd_we),      int'(e.ctl[3]));
      check("pipe_we",    e.cyc, int'(pipe_we),    int'(e.ctl[2]));
      check("retire",     e.cyc, int'(retire),     int'(e.ctl[1]));
      check("halted",     e.cyc, int'(halted),     int'(e.ctl[0]));
      check("valid",      e.cyc, int'({fd_valid, de_valid, em_valid, mw_valid}), int'(e.vld));
      check("stall_cnt",  e.cyc, int'(stall_cnt),  e.st);
      check("flush_cnt",  e.cyc, int'(flush_cnt),  e.fl);
      check("retire_cnt", e.cyc, int'(retire_cnt), e.rc);
      check("small_stall_cnt",  e.cyc, int'(s_stall_cnt),  sat3(e.st));
      check("small_retire_cnt", e.cyc, int'(s_retire_cnt), sat3(e.rc));
      check("small_halted",     e.cyc, int'(s_halted),     int'(e.ctl[0]));
    end
  end

  // Driver: in = {rst, dmem_busy, ld_use_stall, flush, imem_busy, halt_dec}.
  task automatic step(input logic [5:0] in, input logic [4:0] ctl, input logic [3:0] vld,
                      input int st, input int fl, input int rc);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, dmem_busy, ld_use_stall, flush, imem_busy, halt_dec} = in;
    e.cyc = cyc;
    e.ctl = ctl;
    e.vld = vld;
    e.st  = st;
    e.fl  = fl;
    e.rc  = rc;
    sb.push_back(e);
    cyc++;
  endtask

  initial begin
    // Reset held.
    step(6'b100000, 5'b00000, 4'b0000, 0, 0, 0);
    step(6'b100000, 5'b00000, 4'b0000, 0, 0, 0);
    // Fill from empty.
    step(6'b000000, 5'b11100, 4'b0000, 0, 0, 0);
    step(6'b000000, 5'b11100, 4'b1000, 0, 0, 0);
    step(6'b000000, 5'b11100, 4'b1100, 0, 0, 0);
    step(6'b000000, 5'b11100, 4'b1110, 0, 0, 0);
    step(6'b000000, 5'b11110, 4'b1111, 0, 0, 0);
    step(6'b000000, 5'b11110, 4'b1111, 0, 0, 1);
    // Load-use stall for one cycle.
    step(6'b001000, 5'b00110, 4'b1111, 0, 0, 2);
    step(6'b000000, 5'b11110, 4'b1011, 1, 0, 3);
    step(6'b000000, 5'b11110, 4'b1101, 1, 0, 4);
    step(6'b000000, 5'b11100, 4'b1110, 1, 0, 5);
    // Stall beats flush, then flush alone.
    step(6'b001100, 5'b00110, 4'b1111, 1, 0, 5);
    step(6'b000100, 5'b11110, 4'b1011, 2, 0, 6);
    step(6'b000000, 5'b11110, 4'b0101, 2, 1, 7);
    step(6'b000000, 5'b11100, 4'b1010, 2, 1, 8);
    step(6'b000000, 5'b11110, 4'b1101, 2, 1, 8);
    step(6'b000000, 5'b11100, 4'b1110, 2, 1, 9);
    // Data memory busy for 3 cycles.
    step(6'b010000, 5'b00000, 4'b1111, 2, 1, 9);
    step(6'b010000, 5'b00000, 4'b1111, 3, 1, 9);
    step(6'b010000, 5'b00000, 4'b1111, 4, 1, 9);
    step(6'b000000, 5'b11110, 4'b1111, 5, 1, 9);
    // Halt in decode, drain with one freeze and an ignored flush.
    step(6'b000001, 5'b01110, 4'b1111, 5, 1, 10);
    step(6'b000100, 5'b01110, 4'b0111, 5, 1, 11);
    step(6'b010000, 5'b00000, 4'b0011, 5, 1, 12);
    step(6'b000000, 5'b01110, 4'b0011, 5, 1, 12);
    step(6'b000000, 5'b01110, 4'b0001, 5, 1, 13);
    // Halted is sticky and ignores every request.
    step(6'b010110, 5'b00001, 4'b0000, 5, 1, 14);
    step(6'b000000, 5'b00001, 4'b0000, 5, 1, 14);
    // Reset while halted clears everything at once.
    step(6'b100000, 5'b00000, 4'b0000, 0, 0, 0);
    // Instruction memory busy streak: small counters saturate at 3.
    step(6'b000010, 5'b01100, 4'b0000, 0, 0, 0);
    step(6'b000010, 5'b01100, 4'b0000, 1, 0, 0);
    step(6'b000010, 5'b01100, 4'b0000, 2, 0, 0);
    step(6'b000010, 5'b01100, 4'b0000, 3, 0, 0);
    step(6'b000010, 5'b01100, 4'b0000, 4, 0, 0);
    step(6'b000000, 5'b11100, 4'b0000, 5, 0, 0);
    step(6'b000000, 5'b11100, 4'b1000, 5, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", cyc, sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Consumer side of the hazard unit's stall/flush/NOP requests for the 5-stage pipeline. Resolves competing requests (data-memory busy, load-use stall, branch/jump flush, instruction-memory busy, halt) into per-stage write enables and registered per-stage valid bits, drains the pipe on halt, and keeps saturating performance counters. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their enables.

Parameters:
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-high
dmem_busy  in  1  data memory not ready; freeze whole pipe
ld_use_stall  in  1  load-use hazard detected against instruction in decode
flush  in  1  branch/jump taken, resolved in decode
imem_busy  in  1  instruction memory not ready this cycle
halt_dec  in  1  halt instruction present in decode
pc_we  out  1  PC load enable
fd_we  out  1  IF/ID register load enable
pipe_we  out  1  ID/EX, EX/MEM, MEM/WB load enable (common)
fd_valid, de_valid, em_valid, mw_valid  out  1 each  registered stage valid bits
retire  out  1  valid instruction leaves MEM/WB this cycle
halted  out  1  pipe fully drained after halt; sticky
stall_cnt, flush_cnt, retire_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset: all valid bits 0, state RUN, drain counter 0, counters 0, halted 0. While rst=1, pc_we=fd_we=pipe_we=retire=0.
- Out of reset, outputs are combinational from state and inputs; valid bits and counters are registered.
- freeze = dmem_busy & state!=HALTED. pipe_we = ~freeze & state!=HALTED.
- RUN precedence (highest first):
  1 dmem_busy: pc_we=0, fd_we=0, pipe_we=0, all valid bits hold.
  2 ld_use_stall: pc_we=0, fd_we=0; fd holds; de_valid<=0 (bubble); em<=de; mw<=em.
  3 flush: pc_we=1 (target); fd_we=1, fd_valid<=0; de<=fd; em<=de; mw<=em.
  4 halt_dec & fd_valid: pc_we=0, fd_we=1, fd_valid<=0; de<=fd; em<=de; mw<=em; drain<=3; state<=DRAIN.
  5 imem_busy: pc_we=0, fd_we=1, fd_valid<=0; others advance.
  6 else: pc_we=1, fd_we=1, fd_valid<=1; others advance.
- Simultaneous cases:
  - ld_use_stall+flush: stall wins; flush is re-presented next cycle.
  - flush+imem_busy: flush wins.
  - halt_dec+flush: flush wins.
  - halt_dec with fd_valid=0: ignored.
- DRAIN state:
  - pc_we=0, fd_we=1, fd_valid<=0; flush, imem_busy and ld_use_stall ignored; dmem_busy still freezes.
  - Each non-frozen edge: drain decrements and stages advance. Edge with drain==1: state<=HALTED.
- HALTED: all enables 0; all valid bits <=0 at entry; sticky until rst. halted=1 iff state==HALTED.
- retire = mw_valid & ~freeze & state!=HALTED & ~rst.
- Counters (each saturates at 2^CNT_W-1, never wraps):
  - stall_cnt: +1 per RUN cycle with pc_we=0 caused by rule 1, 2 or 5.
  - flush_cnt: +1 per cycle where rule 3 fires.
  - retire_cnt: +1 per retire.
- Reset mid-DRAIN or in HALTED: returns immediately to the reset state.

Decomposition:
- Shared package pipe_pkg: state enum RUN=2'b00, DRAIN=2'b01, HALTED=2'b10; DRAIN_CYCLES=3.
- One sub-module, sat_counter (params W; ports clk, rst, inc, cnt), instantiated three times.
- Priority resolution and valid-bit shift stay in pipe_flow_ctrl.

Test Plan:
- Reset then 5 idle cycles -> pc_we=1 every cycle; fd/de/em/mw_valid become 1 on successive edges; first retire at cycle 4; retire_cnt=2 after cycle 5.
- Steady pipe, ld_use_stall=1 for 1 cycle -> pc_we=0, fd_we=0, de_valid=0 next edge, then mw_valid=0 two edges later; stall_cnt=1.
- flush=1 and ld_use_stall=1 together, then flush alone -> first cycle treated as stall (flush_cnt unchanged); second cycle fd_valid<=0, pc_we=1, flush_cnt=1.
- dmem_busy=1 for 3 cycles with all valid=1 -> all enables 0, valid bits unchanged, retire=0, stall_cnt +3.
- halt_dec with fd_valid=1, dmem_busy pulsed once during DRAIN -> halted asserts 4 edges after entry (3 drain + 1 freeze); mw_valid=0; pc_we stays 0 thereafter.
- CNT_W=2, 5 consecutive imem_busy cycles -> stall_cnt saturates at 3; rst mid-HALTED -> halted=0, counters 0 immediately.
